// File: rtl/bayer_src_pkg.sv
// Shared types and constants for the Bayer test-pattern source.
// The pattern helper covers the modes that depend only on position and level.
package bayer_src_pkg;

    localparam int PIX_W  = 12;
    localparam int CNT_W  = 11;
    localparam int LFSR_W = 16;

    localparam logic [PIX_W-1:0]  PIX_MAX   = {PIX_W{1'b1}};
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 as a bit mask over lfsr[15:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_e;

    typedef enum logic [1:0] {
        SOLID,
        RAMP,
        BARS,
        CHECK_OR_LFSR
    } mode_e;

    function automatic logic [PIX_W-1:0] pix_pattern(
        input mode_e             m,
        input logic [PIX_W-1:0]  lvl,
        input logic [CNT_W-1:0]  x,
        input logic [CNT_W-1:0]  y
    );
        logic [PIX_W-1:0] v;
        case (m)
            SOLID:   v = lvl;
            RAMP:    v = {x, 1'b0};
            BARS:    v = x[7] ? PIX_MAX : '0;
            default: v = (x[4] ^ y[4]) ? PIX_MAX : '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bayer_src_lfsr.sv
// 16-bit Fibonacci LFSR; lfsr_d_o is the value the next pixel will carry.
// Reseeds on init_i (frame start), steps once for every valid pixel.
module bayer_src_lfsr
    import bayer_src_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_i,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] lfsr_d_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (init_i) begin
            lfsr_d = LFSR_SEED;
        end else if (adv_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_d_o = lfsr_d;

endmodule

// File: rtl/bayer_pattern_source.sv
// Raw Bayer test-pattern generator with line/frame timing; all outputs registered.
// Define BAYER_SRC_LFSR_EN to replace the mode-3 checkerboard with an LFSR noise pattern.
module bayer_pattern_source
    import bayer_src_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iEN,
    input  logic [1:0]       iMODE,
    input  logic [PIX_W-1:0] iLEVEL,
    output logic [PIX_W-1:0] oDATA,
    output logic             oDVAL,
    output logic [CNT_W-1:0] oX_Cont,
    output logic [CNT_W-1:0] oY_Cont,
    output logic             oLVAL,
    output logic             oFVAL,
    output logic             oFRAME_DONE
);

    localparam int BLK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic [BLK_W-1:0] HB_LAST = BLK_W'(H_BLANK - 1);
    localparam logic [BLK_W-1:0] VB_LAST = BLK_W'(V_BLANK - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [PIX_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [BLK_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] data_q, data_d;
    logic             dval_q, dval_d;
    logic             fval_q, fval_d;
    logic             done_q, done_d;
    logic             frame_start;

`ifdef BAYER_SRC_LFSR_EN
    logic [LFSR_W-1:0] lfsr_nxt;

    bayer_src_lfsr u_lfsr (
        .clk_i    (iCLK),
        .rst_i    (iRST),
        .init_i   (frame_start),
        .adv_i    (dval_q),
        .lfsr_d_o (lfsr_nxt)
    );
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        level_d     = level_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        dval_d      = 1'b0;
        fval_d      = fval_q;
        done_d      = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            IDLE: frame_start = iEN;
            ACTIVE: begin
                if (x_q == X_LAST) begin
                    state_d = HBLANK;
                    cnt_d   = '0;
                end else begin
                    x_d    = x_q + CNT_W'(1);
                    dval_d = 1'b1;
                end
            end
            HBLANK: begin
                cnt_d = cnt_q + BLK_W'(1);
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = VBLANK;
                        y_d     = '0;
                        fval_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                        x_d     = '0;
                        y_d     = y_q + CNT_W'(1);
                        dval_d  = 1'b1;
                    end
                end
            end
            VBLANK: begin
                cnt_d = cnt_q + BLK_W'(1);
                if (cnt_q == VB_LAST) begin
                    cnt_d = '0;
                    if (iEN) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Mode and level are sampled only here, so mid-frame input changes are ignored
        if (frame_start) begin
            state_d = ACTIVE;
            mode_d  = mode_e'(iMODE);
            level_d = iLEVEL;
            x_d     = '0;
            y_d     = '0;
            dval_d  = 1'b1;
            fval_d  = 1'b1;
        end

        data_d = dval_d ? pix_pattern(mode_d, level_d, x_d, y_d) : '0;
`ifdef BAYER_SRC_LFSR_EN
        if (dval_d && (mode_d == CHECK_OR_LFSR)) begin
            data_d = lfsr_nxt[PIX_W-1:0];
        end
`endif
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            mode_q  <= SOLID;
            level_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            dval_q  <= 1'b0;
            fval_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dval_q  <= dval_d;
            fval_q  <= fval_d;
            done_q  <= done_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oLVAL       = dval_q;
    assign oFVAL       = fval_q;
    assign oFRAME_DONE = done_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;

endmodule

// File: tb/tb_bayer_pattern_source.sv
// Directed bench for bayer_pattern_source at 8x4 active, 2 HBLANK, 3 VBLANK.
module tb_bayer_pattern_source;

    localparam int HA    = 8;
    localparam int VA    = 4;
    localparam int HB    = 2;
    localparam int VB    = 3;
    localparam int LINE  = HA + HB;
    localparam int ACT   = LINE * VA;
    localparam int FRAME = ACT + VB;

    logic        iCLK;
    logic        iRST;
    logic        iEN;
    logic [1:0]  iMODE;
    logic [11:0] iLEVEL;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic        oLVAL;
    logic        oFVAL;
    logic        oFRAME_DONE;

    int total = 0;
    int bad   = 0;

    bayer_pattern_source #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .V_BLANK  (VB)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iEN         (iEN),
        .iMODE       (iMODE),
        .iLEVEL      (iLEVEL),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oLVAL       (oLVAL),
        .oFVAL       (oFVAL),
        .oFRAME_DONE (oFRAME_DONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic step;
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] exp_pix(input int m, input logic [11:0] lvl, input int x, input int y);
        case (m)
            0:       return lvl;
            1:       return 12'(x * 2);
            2:       return ((x & 128) != 0) ? 12'hFFF : 12'h000;
            default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    function automatic logic [31:0] ctl(input logic dv, input logic fv, input logic dn, input int x, input int y);
        return {6'd0, dv, dv, fv, dn, 11'(x), 11'(y)};
    endfunction

    // Checks ncyc cycles starting at the first-pixel sample of a frame
    task automatic run_frame(input int m, input logic [11:0] lvl, input int ncyc,
                             input int chg_c, input logic chg_en, input logic [1:0] chg_mode,
                             input int fidx);
        int          nd;
        int          ex, ey, pos;
        logic        edv, efv, edn;
        logic [11:0] edat;
        logic [15:0] lf;
        nd = 0;
        lf = 16'hACE1;
        for (int c = 0; c < ncyc; c++) begin
            pos = c % LINE;
            if (c < ACT) begin
                edv = (pos < HA);
                ex  = (pos < HA) ? pos : HA - 1;
                ey  = c / LINE;
                efv = 1'b1;
                edn = 1'b0;
            end else begin
                edv = 1'b0;
                ex  = HA - 1;
                ey  = 0;
                efv = 1'b0;
                edn = (c == ACT);
            end
            check($sformatf("f%0d c%0d ctl", fidx, c),
                  ctl(oDVAL, oFVAL, oFRAME_DONE, int'(oX_Cont), int'(oY_Cont)),
                  ctl(edv, efv, edn, ex, ey));
            if (edv) begin
                edat = exp_pix(m, lvl, ex, ey);
`ifdef BAYER_SRC_LFSR_EN
                if (m == 3) begin
                    edat = lf[11:0];
                    lf   = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
                end
`endif
                check($sformatf("f%0d c%0d data", fidx, c), {20'd0, oDATA}, {20'd0, edat});
                nd++;
            end
            if (c == chg_c) begin
                iEN   = chg_en;
                iMODE = chg_mode;
            end
            step;
        end
        if (ncyc == FRAME) check($sformatf("f%0d dval_count", fidx), nd, HA * VA);
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s idle%0d", tag, i),
                  ctl(oDVAL, oFVAL, oFRAME_DONE, int'(oX_Cont), int'(oY_Cont)),
                  ctl(1'b0, 1'b0, 1'b0, HA - 1, 0));
            step;
        end
    endtask

    initial begin
        iRST   = 1'b1;
        iEN    = 1'b0;
        iMODE  = 2'd0;
        iLEVEL = 12'h000;
        step;
        check("reset ctl", ctl(oDVAL, oFVAL, oFRAME_DONE, int'(oX_Cont), int'(oY_Cont)), ctl(1'b0, 1'b0, 1'b0, 0, 0));
        check("reset data", {20'd0, oDATA}, 32'd0);

        iRST = 1'b0;
        step;
        step;
        check("idle no_en", {30'd0, oDVAL, oFVAL}, 32'd0);

        // Solid level, continuous frames; mode change mid-frame 1 takes effect at frame 2
        iEN    = 1'b1;
        iMODE  = 2'd0;
        iLEVEL = 12'h5A5;
        step;
        run_frame(0, 12'h5A5, FRAME, -1, 1'b1, 2'd0, 0);
        run_frame(0, 12'h5A5, FRAME, 20, 1'b1, 2'd1, 1);
        // Ramp frame; iEN dropped early must not truncate it
        run_frame(1, 12'h5A5, FRAME, 5, 1'b0, 2'd1, 2);
        check_idle(4, "after_ramp");

        // Single-cycle iEN pulse gives exactly one frame
        iEN    = 1'b1;
        iMODE  = 2'd0;
        iLEVEL = 12'h123;
        step;
        iEN   = 1'b0;
        iMODE = 2'd2;
        run_frame(0, 12'h123, FRAME, -1, 1'b0, 2'd2, 3);
        check_idle(4, "after_pulse");

        // Mode 3 twice back to back, then a solid frame interrupted by reset
        iEN   = 1'b1;
        iMODE = 2'd3;
        step;
        run_frame(3, 12'h123, FRAME, -1, 1'b1, 2'd3, 4);
        run_frame(3, 12'h123, FRAME, 30, 1'b1, 2'd0, 5);
        run_frame(0, 12'h123, 23, -1, 1'b1, 2'd0, 6);
        check("pre_reset pos", ctl(oDVAL, oFVAL, oFRAME_DONE, int'(oX_Cont), int'(oY_Cont)), ctl(1'b1, 1'b1, 1'b0, 3, 2));

        #2;
        iRST = 1'b1;
        #1;
        check("async_reset ctl", ctl(oDVAL, oFVAL, oFRAME_DONE, int'(oX_Cont), int'(oY_Cont)), ctl(1'b0, 1'b0, 1'b0, 0, 0));
        check("async_reset data", {20'd0, oDATA}, 32'd0);
        step;
        check("held_reset dval", {31'd0, oDVAL}, 32'd0);
        iRST = 1'b0;
        step;
        check("restart ctl", ctl(oDVAL, oFVAL, oFRAME_DONE, int'(oX_Cont), int'(oY_Cont)), ctl(1'b1, 1'b1, 1'b0, 0, 0));
        check("restart data", {20'd0, oDATA}, 32'h123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
